uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//  Parametrised command-frame decoder between uart_recv and the channel config logic.
//  Collects a framed byte stream: HDR, ADDR, MODE, DATA (MSB byte first), CSUM, TAIL.
//  Validates the frame, updates one of NUM_CH channel register banks, and emits trig/trp strobes.
//  Generalises the fixed 9-byte decoder with: variable data width, multi-channel banks,
//  XOR checksum, per-byte timeout, and error reporting.
// PARAMETERS
//  DATA_BYTES  3       data field bytes; DW=8*DATA_BYTES; FRAME_LEN=DATA_BYTES+5
//  NUM_CH      4       channel banks; ADDR_W=max(1,clog2(NUM_CH))
//  HDR_BYTE    8'hFF   frame header
//  TAIL_BYTE   8'hAA   frame tail
//  BYTE_TMO    6000    max cycles between byte strobes inside a frame (~1 byte @115200, 50 MHz)
//  TRP_DLY     4       cycles from trig to trp rise
//  TRP_LEN     10      trp high time in cycles
// PORTS
//  sys_clk    in   1            clock
//  sys_rst    in   1            synchronous reset, active-low
//  rx_done    in   1            byte-valid from uart_recv; acted on at its rising edge only
//  rx_data    in   8            received byte, stable while rx_done high
//  addr       out  ADDR_W       address of last applied frame
//  mode_sel   out  6            MODE[5:0] of last applied frame
//  data       out  DW           DATA of last applied frame
//  ch_data    out  NUM_CH*DW    per-channel data; channel k at [k*DW +: DW]
//  ch_mode    out  NUM_CH*6     per-channel mode; channel k at [k*6 +: 6]
//  trig       out  1            1-cycle pulse, outputs updated this cycle
//  trp        out  1            external trigger, TRP_LEN cycles wide
//  frame_err  out  1            1-cycle pulse on any rejected frame
//  err_code   out  2            latched last error: 0 none, 1 timeout, 2 csum/tail, 3 bad addr
//  err_cnt    out  8            rejected-frame count, saturates at 255
// BEHAVIOUR
//  Reset (sys_rst=0 at a sys_clk edge):
//   - addr=0, mode_sel=6'd1, data=0; every ch_mode=6'd1, every ch_data=0.
//   - trig=trp=frame_err=0; err_code=0; err_cnt=0; FSM to IDLE; partial frame discarded.
//  Byte strobe: internal edge detect on registered rx_done. One strobe per rx_done high period.
//  FSM:
//   - IDLE: strobe with HDR_BYTE -> RECV; idx=1; timer=0. Other bytes dropped silently, no error.
//   - RECV: each strobe stores byte idx, idx++, timer cleared.
//     timer reaches BYTE_TMO with no strobe -> ERR(1).
//     Strobe of byte FRAME_LEN-1 (tail) -> CHECK.
//   - CHECK (1 cycle), first failure wins:
//     tail!=TAIL_BYTE or CSUM != XOR(ADDR,MODE,DATA bytes) -> ERR(2);
//     ADDR>=NUM_CH or ADDR[7:ADDR_W]!=0 -> ERR(3);
//     else -> APPLY.
//   - APPLY (1 cycle): addr/mode_sel/data and bank[ADDR] registered; trig=1 next cycle with
//     new values visible; -> IDLE.
//   - ERR (1 cycle): err_code set; frame_err pulse; err_cnt++ (sat); no output changes; -> IDLE.
//  Latency: tail strobe cycle T -> CHECK T+1 -> APPLY T+2 -> trig and outputs at T+3.
//  trp rises TRP_DLY cycles after trig, holds TRP_LEN cycles. A new trig restarts the delay.
//  Header inside a frame is data, not resync; bad tail equal to HDR is still ERR(2).
//  Strobes arriving in CHECK/APPLY/ERR are dropped; the sender must space frames >=1 byte time.
//  MODE[7:6] ignored. err_code keeps the last error until reset; a good frame does not clear it.
// TESTING (NUM_CH=4, DATA_BYTES=3, defaults)
//  1. FF 02 05 12 34 56 77 AA -> addr=2, mode_sel=5, data=24'h123456, ch_data[2]=123456, trig at T+3.
//  2. Same frame, CSUM=78 -> frame_err pulse, err_code=2, err_cnt=1, all outputs unchanged.
//  3. FF 07 ... (valid CSUM) -> err_code=3, no bank written; FF 03 ... -> bank 3 updated.
//  4. FF 01 02, then 6000 idle cycles -> err_code=1; following full frame accepted normally.
//  5. 00 55 junk then valid frame -> no error, frame applied; trp high cycles trig+4..trig+13.
//  6. Reset asserted mid-frame after byte 4 -> all outputs at reset values; next frame decodes.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: frames HDR/ADDR/MODE/DATA/CSUM/TAIL bytes into per-channel register banks with trig/trp strobes and error reporting
module uart_frame_decoder #(
    parameter int          DATA_BYTES = 3,
    parameter int          NUM_CH     = 4,
    parameter logic [7:0]  HDR_BYTE   = 8'hFF,
    parameter logic [7:0]  TAIL_BYTE  = 8'hAA,
    parameter int          BYTE_TMO   = 6000,
    parameter int          TRP_DLY    = 4,
    parameter int          TRP_LEN    = 10,
    localparam int         DW         = 8 * DATA_BYTES,
    localparam int         FRAME_LEN  = DATA_BYTES + 5,
    localparam int         ADDR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   rx_done,
    input  logic [7:0]             rx_data,
    output logic [ADDR_W-1:0]      addr,
    output logic [5:0]             mode_sel,
    output logic [DW-1:0]          data,
    output logic [NUM_CH*DW-1:0]   ch_data,
    output logic [NUM_CH*6-1:0]    ch_mode,
    output logic                   trig,
    output logic                   trp,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic [7:0]             err_cnt
);
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(BYTE_TMO + 1);
    localparam int CW = $clog2(TRP_DLY + TRP_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_APPLY, S_ERR} state_t;

    state_t            r_state, w_next;
    logic              r_rx_d;
    logic              w_stb;
    logic [7:0]        r_buf [1:FRAME_LEN-1];
    logic [IW-1:0]     r_idx;
    logic [TW-1:0]     r_timer;
    logic [1:0]        r_ecode, w_ecode;
    logic [7:0]        w_csum;
    logic [DW-1:0]     w_data;
    logic [ADDR_W-1:0] w_addr;
    logic [CW-1:0]     r_tcnt;
    logic              r_trig, r_ferr;
    logic [ADDR_W-1:0] r_addr;
    logic [5:0]        r_mode;
    logic [DW-1:0]     r_data;
    logic [DW-1:0]     r_ch_data [NUM_CH];
    logic [5:0]        r_ch_mode [NUM_CH];
    logic [1:0]        r_err_code;
    logic [7:0]        r_err_cnt;

    assign w_stb  = rx_done & ~r_rx_d;
    assign w_addr = r_buf[1][ADDR_W-1:0];

    always_comb begin
        w_csum = '0;
        w_data = '0;
        for (int i = 1; i < DATA_BYTES + 3; i++) w_csum ^= r_buf[i];
        for (int i = 0; i < DATA_BYTES; i++) w_data[(DATA_BYTES-1-i)*8 +: 8] = r_buf[3+i];
    end

    always_ff @(posedge sys_clk) r_state <= !sys_rst ? S_IDLE : w_next;

    always_comb begin
        w_next  = r_state;
        w_ecode = r_ecode;
        case (r_state)
            S_IDLE:  w_next = (w_stb && rx_data == HDR_BYTE) ? S_RECV : S_IDLE;
            S_RECV: begin
                if (w_stb && r_idx == IW'(FRAME_LEN - 1)) begin
                    w_next = S_CHECK;
                end else if (!w_stb && r_timer == TW'(BYTE_TMO)) begin
                    w_next  = S_ERR;
                    w_ecode = 2'd1;
                end
            end
            // integrity errors take priority over a bad address
            S_CHECK: begin
                if (r_buf[FRAME_LEN-1] != TAIL_BYTE || r_buf[DATA_BYTES+3] != w_csum) begin
                    w_next  = S_ERR;
                    w_ecode = 2'd2;
                end else if ({1'b0, r_buf[1]} >= 9'(NUM_CH)) begin
                    w_next  = S_ERR;
                    w_ecode = 2'd3;
                end else begin
                    w_next = S_APPLY;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_rx_d     <= 1'b0;
            r_idx      <= IW'(1);
            r_timer    <= '0;
            r_ecode    <= '0;
            r_trig     <= 1'b0;
            r_ferr     <= 1'b0;
            r_tcnt     <= '0;
            r_addr     <= '0;
            r_mode     <= 6'd1;
            r_data     <= '0;
            r_err_code <= '0;
            r_err_cnt  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_ch_data[i] <= '0;
                r_ch_mode[i] <= 6'd1;
            end
        end else begin
            r_rx_d  <= rx_done;
            r_ecode <= w_ecode;
            r_trig  <= (r_state == S_APPLY);
            r_ferr  <= (r_state == S_ERR);
            r_tcnt  <= r_trig ? CW'(1) :
                       (r_tcnt != '0 && r_tcnt != CW'(TRP_DLY + TRP_LEN)) ? r_tcnt + 1'b1 : '0;
            if (r_state == S_IDLE) begin
                r_idx   <= IW'(1);
                r_timer <= '0;
            end
            if (r_state == S_RECV) begin
                r_timer <= w_stb ? '0 : r_timer + 1'b1;
                if (w_stb) begin
                    r_buf[r_idx] <= rx_data;
                    r_idx        <= r_idx + 1'b1;
                end
            end
            if (r_state == S_APPLY) begin
                r_addr            <= w_addr;
                r_mode            <= r_buf[2][5:0];
                r_data            <= w_data;
                r_ch_data[w_addr] <= w_data;
                r_ch_mode[w_addr] <= r_buf[2][5:0];
            end
            if (r_state == S_ERR) begin
                r_err_code <= r_ecode;
                r_err_cnt  <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign ch_data[k*DW +: DW] = r_ch_data[k];
        assign ch_mode[k*6 +: 6]   = r_ch_mode[k];
    end

    assign addr      = r_addr;
    assign mode_sel  = r_mode;
    assign data      = r_data;
    assign trig      = r_trig;
    assign frame_err = r_ferr;
    assign err_code  = r_err_code;
    assign err_cnt   = r_err_cnt;
    assign trp       = (r_tcnt >= CW'(TRP_DLY)) && (r_tcnt < CW'(TRP_DLY + TRP_LEN));
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: table-driven frames with a reference model and event scoreboard
module tb_uart_frame_decoder;
    localparam int DW = 24;
    localparam int NC = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b0;
    logic             rx_done = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic [1:0]       addr;
    logic [5:0]       mode_sel;
    logic [DW-1:0]    data;
    logic [NC*DW-1:0] ch_data;
    logic [NC*6-1:0]  ch_mode;
    logic             trig, trp, frame_err;
    logic [1:0]       err_code;
    logic [7:0]       err_cnt;

    uart_frame_decoder dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_done(rx_done), .rx_data(rx_data),
        .addr(addr), .mode_sel(mode_sel), .data(data), .ch_data(ch_data), .ch_mode(ch_mode),
        .trig(trig), .trp(trp), .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_err;
        logic [1:0]  a;
        logic [5:0]  m;
        logic [23:0] d;
        logic [95:0] chd;
        logic [23:0] chm;
        logic [1:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  m;
        logic [23:0] d;
        logic [7:0]  delta;
        logic [7:0]  tail;
        bit          is_err;
        logic [1:0]  code;
    } vec_t;

    exp_t        q[$];
    logic [1:0]  m_a;
    logic [5:0]  m_m;
    logic [23:0] m_d;
    logic [95:0] m_chd;
    logic [23:0] m_chm;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_m = 6'd1; m_d = 0; m_chd = 0; m_chm = {4{6'd1}}; m_code = 0; m_cnt = 0;
        q.delete();
    endtask

    task automatic push(bit is_err, logic [7:0] a, logic [7:0] m, logic [23:0] d, logic [1:0] code);
        if (!is_err) begin
            m_a = a[1:0]; m_m = m[5:0]; m_d = d;
            m_chd[a[1:0]*24 +: 24] = d;
            m_chm[a[1:0]*6 +: 6]   = m[5:0];
        end else begin
            m_code = code;
            if (m_cnt != 8'hFF) m_cnt++;
        end
        q.push_back('{is_err, m_a, m_m, m_d, m_chd, m_chm, m_code, m_cnt});
    endtask

    // rx_done held two cycles to exercise the single-strobe edge detect
    task automatic send_byte(logic [7:0] b);
        @(negedge sys_clk) rx_data = b; rx_done = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk) rx_done = 1'b0;
        @(negedge sys_clk);
    endtask

    function automatic logic [7:0] csum(logic [7:0] a, logic [7:0] m, logic [23:0] d);
        return a ^ m ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    task automatic send_frame(logic [7:0] a, logic [7:0] m, logic [23:0] d, logic [7:0] delta, logic [7:0] tail);
        send_byte(8'hFF); send_byte(a); send_byte(m);
        send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
        send_byte(csum(a, m, d) ^ delta); send_byte(tail);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge sys_clk) #2;
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", addr, 0); chk("rst_mode", mode_sel, 1); chk("rst_data", data, 0);
        chk("rst_ch_data", ch_data, 0); chk("rst_ch_mode", ch_mode, {4{6'd1}});
        chk("rst_strobes", {trig, trp, frame_err}, 0);
        chk("rst_err_code", err_code, 0); chk("rst_err_cnt", err_cnt, 0);
    endtask

    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (trig || frame_err) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_event trig=%b frame_err=%b", trig, frame_err);
            end else begin
                e = q.pop_front();
                chk("ev_frame_err", frame_err, e.is_err);
                chk("ev_trig", trig, !e.is_err);
                chk("ev_addr", addr, e.a);
                chk("ev_mode", mode_sel, e.m);
                chk("ev_data", data, e.d);
                chk("ev_ch_data", ch_data, e.chd);
                chk("ev_ch_mode", ch_mode, e.chm);
                chk("ev_err_code", err_code, e.code);
                chk("ev_err_cnt", err_cnt, e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic [7:0]  c;
        int          n;
        vecs = '{
            '{8'h02, 8'h05, 24'h123456, 8'h00, 8'hAA, 1'b0, 2'd0},
            '{8'h02, 8'h05, 24'h123456, 8'h0F, 8'hAA, 1'b1, 2'd2},
            '{8'h07, 8'h05, 24'h123456, 8'h00, 8'hAA, 1'b1, 2'd3},
            '{8'h03, 8'h11, 24'hABCDEF, 8'h00, 8'hAA, 1'b0, 2'd0},
            '{8'h00, 8'hC5, 24'hFF00FF, 8'h00, 8'hAA, 1'b0, 2'd0},
            '{8'h01, 8'h3F, 24'h000001, 8'h00, 8'h55, 1'b1, 2'd2},
            '{8'h01, 8'h3F, 24'h000001, 8'h00, 8'hFF, 1'b1, 2'd2},
            '{8'h82, 8'h01, 24'h000000, 8'h00, 8'hAA, 1'b1, 2'd3},
            '{8'h04, 8'h01, 24'h000000, 8'h00, 8'hAA, 1'b1, 2'd3},
            '{8'h07, 8'h01, 24'h000000, 8'h01, 8'hAA, 1'b1, 2'd2},
            '{8'h01, 8'h3F, 24'h000001, 8'h00, 8'hAA, 1'b0, 2'd0}
        };
        model_reset();
        repeat (3) @(negedge sys_clk);
        chk_reset_vals();
        sys_rst = 1'b1;

        foreach (vecs[i]) begin
            push(vecs[i].is_err, vecs[i].a, vecs[i].m, vecs[i].d, vecs[i].code);
            send_frame(vecs[i].a, vecs[i].m, vecs[i].d, vecs[i].delta, vecs[i].tail);
            drain();
        end

        // exact trig latency from the tail strobe, then the trp window
        c = csum(8'h01, 8'h2A, 24'hC0FFEE);
        push(1'b0, 8'h01, 8'h2A, 24'hC0FFEE, 2'd0);
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h2A);
        send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hEE); send_byte(c);
        @(negedge sys_clk) rx_data = 8'hAA; rx_done = 1'b1;
        @(posedge sys_clk) #1 rx_done = 1'b0;
        @(posedge sys_clk) #1 chk("trig_T+2", trig, 0);
        @(posedge sys_clk) #1 chk("trig_T+3", trig, 1);
        for (int k = 1; k <= 15; k++) begin
            @(posedge sys_clk) #1 chk($sformatf("trp_t+%0d", k), trp, (k >= 4 && k <= 13));
        end
        drain();

        send_byte(8'h00); send_byte(8'h55);
        push(1'b0, 8'h02, 8'h09, 24'h5A5A5A, 2'd0);
        send_frame(8'h02, 8'h09, 24'h5A5A5A, 8'h00, 8'hAA);
        drain();

        push(1'b1, 8'h00, 8'h00, 24'h0, 2'd1);
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h02);
        n = 0;
        while (n < 7000 && !frame_err) begin
            @(posedge sys_clk) #1 n++;
        end
        chk("timeout_seen", frame_err, 1);
        chk("timeout_window", (n >= 5990 && n <= 6005), 1);
        drain();
        push(1'b0, 8'h03, 8'h22, 24'h010203, 2'd0);
        send_frame(8'h03, 8'h22, 24'h010203, 8'h00, 8'hAA);
        drain();

        for (int i = 0; i < 250; i++) begin
            push(1'b1, 8'h05, 8'h01, 24'h0, 2'd3);
            send_frame(8'h05, 8'h01, 24'h0, 8'h00, 8'hAA);
            drain();
        end
        chk("err_cnt_sat", err_cnt, 8'hFF);

        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h05); send_byte(8'h12);
        @(negedge sys_clk) sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_reset_vals();
        sys_rst = 1'b1;
        push(1'b0, 8'h02, 8'h05, 24'h123456, 2'd0);
        send_frame(8'h02, 8'h05, 24'h123456, 8'h00, 8'hAA);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
